// File: rtl/camera_wr_packer_pkg.sv
// rtl/camera_wr_packer_pkg.sv - shared types and constants for the camera write packer
package camera_wr_packer_pkg;

  localparam int PIX_PER_WORD = 8;
  localparam int PIX_W        = 16;
  localparam int DDR_ADDR_W   = 25;
  localparam int DDR_DATA_W   = 128;
  localparam logic [DDR_ADDR_W-1:0] FRAME_STRIDE_DEFAULT = 25'h0080000;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  // Address travels with the data so dropped words never shift later addresses.
  typedef struct packed {
    logic [DDR_DATA_W-1:0] data;
    logic [DDR_ADDR_W-1:0] addr;
  } wr_word_t;

  function automatic logic [DDR_ADDR_W-1:0] word_addr(
    input logic [DDR_ADDR_W-1:0] base,
    input logic [DDR_ADDR_W-1:0] index
  );
    return base + (index << $clog2(PIX_PER_WORD));
  endfunction

endpackage

// File: rtl/pack_word_fifo.sv
// rtl/pack_word_fifo.sv - synchronous word FIFO with flush and push-while-full-and-popping
module pack_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // The head is read combinationally, so a full FIFO may overwrite it on the popping edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/camera_wr_packer.sv
// rtl/camera_wr_packer.sv - packs RGB565 pixels into 128-bit DDR write requests per frame
module camera_wr_packer
  import camera_wr_packer_pkg::*;
#(
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    FRAME_WORDS  = 38400,
  parameter logic [DDR_ADDR_W-1:0] FRAME_STRIDE = FRAME_STRIDE_DEFAULT
) (
  input  logic                  clk_133M,
  input  logic                  rst_n_133M,
  input  logic                  init_done,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [1:0]            exp_sel,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  ram_busy,
  output logic                  camera_wr_req,
  output logic [DDR_DATA_W-1:0] camera_wr_data,
  output logic [DDR_ADDR_W-1:0] camera_wr_address,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int LANE_W = $clog2(PIX_PER_WORD);
  localparam int IDX_W  = $clog2(FRAME_WORDS + 1);

  state_t                state;
  state_t                state_nxt;
  logic [LANE_W-1:0]     lane;
  logic [DDR_DATA_W-1:0] word_acc;
  logic [DDR_DATA_W-1:0] word_fill;
  logic [IDX_W-1:0]      word_index;
  logic [DDR_ADDR_W-1:0] base_addr;
  logic                  push_pend;
  wr_word_t              pend_word;
  wr_word_t              head;
  logic                  restart;
  logic                  accept;
  logic                  word_done;
  logic                  pad_done;
  logic                  word_close;
  logic                  last_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  req;
  logic                  req_prev;

  assign restart    = frame_start && ((state != IDLE) || init_done);
  assign accept     = (state == CAPTURE) && pix_valid && !frame_start;
  assign word_done  = accept && (lane == LANE_W'(PIX_PER_WORD - 1));
  // A partial word (including one completed by a pixel in the frame_end cycle) is padded out.
  assign pad_done   = (state == CAPTURE) && frame_end && !frame_start && !word_done
                      && (accept || (lane != '0));
  assign word_close = word_done || pad_done;
  assign last_word  = word_done && (word_index == IDX_W'(FRAME_WORDS - 1));

  always_comb begin
    word_fill = word_acc;
    if (accept) word_fill[lane*PIX_W +: PIX_W] = pix_data;
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (restart) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (restart)                       state_nxt = CAPTURE;
        else if (frame_end || last_word)   state_nxt = DRAIN;
      end
      DRAIN: begin
        if (restart) begin
          state_nxt = CAPTURE;
        end else if (fifo_empty && !push_pend) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      lane       <= '0;
      word_acc   <= '0;
      word_index <= '0;
      base_addr  <= '0;
      push_pend  <= 1'b0;
      pend_word  <= '0;
      overflow   <= 1'b0;
      req_prev   <= 1'b0;
    end else begin
      req_prev <= req;
      if (push_pend && fifo_full && !req && !restart) overflow <= 1'b1;
      if (restart) begin
        lane       <= '0;
        word_acc   <= '0;
        word_index <= '0;
        push_pend  <= 1'b0;
        base_addr  <= FRAME_STRIDE * DDR_ADDR_W'(exp_sel);
      end else begin
        push_pend <= word_close;
        if (word_close) begin
          pend_word.data <= word_fill;
          pend_word.addr <= word_addr(base_addr, DDR_ADDR_W'(word_index));
          word_acc       <= '0;
          lane           <= '0;
          word_index     <= word_index + 1'b1;
        end else if (accept) begin
          word_acc <= word_fill;
          lane     <= lane + 1'b1;
        end
      end
    end
  end

  pack_word_fifo #(
    .WIDTH($bits(wr_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_133M),
    .rst_n    (rst_n_133M),
    .flush    (restart),
    .push     (push_pend),
    .push_data(pend_word),
    .pop      (req),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The arbiter's busy flag lags by a cycle, hence the forced idle cycle after each request.
  assign req               = init_done && !fifo_empty && !ram_busy && !req_prev && !restart;
  assign camera_wr_req     = req;
  assign camera_wr_data    = req ? head.data : '0;
  assign camera_wr_address = req ? head.addr : '0;

endmodule

// File: tb/tb_camera_wr_packer.sv
// tb/tb_camera_wr_packer.sv - self-checking bench for camera_wr_packer
module tb_camera_wr_packer;

  localparam int FW     = 16;
  localparam int STRIDE = 'h80000;

  logic         clk_133M = 1'b0;
  logic         rst_n_133M = 1'b0;
  logic         init_done = 1'b0;
  logic         frame_start = 1'b0;
  logic         frame_end = 1'b0;
  logic [1:0]   exp_sel = 2'd0;
  logic         pix_valid = 1'b0;
  logic [15:0]  pix_data = 16'h0;
  logic         ram_busy = 1'b0;
  logic         camera_wr_req;
  logic [127:0] camera_wr_data;
  logic [24:0]  camera_wr_address;
  logic         frame_done;
  logic         overflow;

  camera_wr_packer #(
    .FIFO_DEPTH  (4),
    .FRAME_WORDS (FW),
    .FRAME_STRIDE(25'h0080000)
  ) dut (
    .clk_133M         (clk_133M),
    .rst_n_133M       (rst_n_133M),
    .init_done        (init_done),
    .frame_start      (frame_start),
    .frame_end        (frame_end),
    .exp_sel          (exp_sel),
    .pix_valid        (pix_valid),
    .pix_data         (pix_data),
    .ram_busy         (ram_busy),
    .camera_wr_req    (camera_wr_req),
    .camera_wr_data   (camera_wr_data),
    .camera_wr_address(camera_wr_address),
    .frame_done       (frame_done),
    .overflow         (overflow)
  );

  always #5 clk_133M = ~clk_133M;

  typedef struct {
    logic [1:0]   es;
    int           npix;
    logic [15:0]  p0;
    logic [15:0]  step;
    bit           eol;
    int           nreq;
    logic [24:0]  a_first;
    logic [127:0] d_first;
    logic [24:0]  a_last;
    logic [127:0] d_last;
  } vec_t;

  int           checks = 0;
  int           fails = 0;
  int           done_cnt = 0;
  bit           prev_req = 1'b0;
  bit           busy_mode = 1'b0;
  logic [24:0]  obs_addr[$];
  logic [127:0] obs_data[$];
  logic [24:0]  exp_addr[$];
  logic [127:0] exp_data[$];
  logic [15:0]  pix_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe outputs on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk_133M);
    if (rst_n_133M && camera_wr_req) begin
      chk("req_protocol", {125'd0, prev_req, ram_busy, !init_done}, 128'd0);
      obs_addr.push_back(camera_wr_address);
      obs_data.push_back(camera_wr_data);
    end
    if (frame_done) done_cnt++;
    prev_req = camera_wr_req;
    @(posedge clk_133M);
    #1;
    if (busy_mode) ram_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_timeout", 128'(done_cnt >= target), 128'd1);
  endtask

  task automatic run_frame(input logic [1:0] es, input bit gaps, input bit eol);
    frame_start = 1'b1;
    exp_sel     = es;
    tick();
    frame_start = 1'b0;
    exp_sel     = ~es;
    for (int i = 0; i < pix_q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      pix_valid = 1'b1;
      pix_data  = pix_q[i];
      if (eol && i == pix_q.size() - 1) frame_end = 1'b1;
      tick();
      pix_valid = 1'b0;
      frame_end = 1'b0;
    end
    if (!eol) begin
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
    end
  endtask

  task automatic build_expect(input logic [1:0] es);
    int           nw;
    logic [127:0] d;
    exp_addr.delete();
    exp_data.delete();
    nw = (pix_q.size() + 7) / 8;
    if (nw > FW) nw = FW;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int k = 0; k < 8; k++)
        if (8 * w + k < pix_q.size()) d[16*k +: 16] = pix_q[8*w+k];
      exp_data.push_back(d);
      exp_addr.push_back(25'((int'(es) * STRIDE + 8 * w) % 33554432));
    end
  endtask

  task automatic compare_words(input int base, input string tag);
    chk({tag, "_count"}, 128'(obs_addr.size() - base), 128'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && base + i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, 128'(obs_addr[base+i]), 128'(exp_addr[i]));
      chk({tag, "_data"}, obs_data[base+i], exp_data[i]);
    end
  endtask

  task automatic send_pixels(input int n, input logic [15:0] first);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_data  = first + 16'(k);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    int          base;
    int          target;
    int          last;
    logic [1:0]  es;
    int          n;
    logic [15:0] p;

    vecs[0] = '{2'd2, 16, 16'h0001, 16'h0001, 1'b0, 2,
                25'h0100000, 128'h0008_0007_0006_0005_0004_0003_0002_0001,
                25'h0100008, 128'h0010_000f_000e_000d_000c_000b_000a_0009};
    vecs[1] = '{2'd0, 3, 16'hAAAA, 16'h0000, 1'b0, 1,
                25'h0000000, 128'h0000_0000_0000_0000_0000_AAAA_AAAA_AAAA,
                25'h0000000, 128'h0000_0000_0000_0000_0000_AAAA_AAAA_AAAA};
    vecs[2] = '{2'd1, 8, 16'h1000, 16'h0101, 1'b1, 1,
                25'h0080000, 128'h1707_1606_1505_1404_1303_1202_1101_1000,
                25'h0080000, 128'h1707_1606_1505_1404_1303_1202_1101_1000};
    vecs[3] = '{2'd3, 9, 16'hFFFF, 16'hFFFF, 1'b1, 2,
                25'h0180000, 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF,
                25'h0180008, 128'h0000_0000_0000_0000_0000_0000_0000_FFF7};
    vecs[4] = '{2'd1, FW * 8 + 8, 16'h0000, 16'h0001, 1'b0, FW,
                25'h0080000, 128'h0007_0006_0005_0004_0003_0002_0001_0000,
                25'h0080078, 128'h007f_007e_007d_007c_007b_007a_0079_0078};

    repeat (3) tick();
    chk("reset_ctrl", {125'd0, camera_wr_req, frame_done, overflow}, 128'd0);
    chk("reset_addr", 128'(camera_wr_address), 128'd0);
    chk("reset_data", camera_wr_data, 128'd0);

    // Frame attempted before DDR init must be ignored.
    rst_n_133M = 1'b1;
    tick();
    pix_q.delete();
    for (int k = 0; k < 8; k++) pix_q.push_back(16'h0F00 + 16'(k));
    run_frame(2'd1, 1'b0, 1'b0);
    repeat (5) tick();
    chk("init_block_reqs", 128'(obs_addr.size()), 128'd0);
    chk("init_block_done", 128'(done_cnt), 128'd0);
    init_done = 1'b1;
    tick();

    foreach (vecs[v]) begin
      pix_q.delete();
      for (int k = 0; k < vecs[v].npix; k++) begin
        p = vecs[v].p0 + 16'(k) * vecs[v].step;
        pix_q.push_back(p);
      end
      base   = obs_addr.size();
      target = done_cnt + 1;
      run_frame(vecs[v].es, 1'b0, vecs[v].eol);
      wait_done(target, 400);
      repeat (4) tick();
      chk($sformatf("vec%0d_nreq", v), 128'(obs_addr.size() - base), 128'(vecs[v].nreq));
      if (obs_addr.size() > base) begin
        last = obs_addr.size() - 1;
        chk($sformatf("vec%0d_first_addr", v), 128'(obs_addr[base]), 128'(vecs[v].a_first));
        chk($sformatf("vec%0d_first_data", v), obs_data[base], vecs[v].d_first);
        chk($sformatf("vec%0d_last_addr", v), 128'(obs_addr[last]), 128'(vecs[v].a_last));
        chk($sformatf("vec%0d_last_data", v), obs_data[last], vecs[v].d_last);
      end
      chk($sformatf("vec%0d_done_once", v), 128'(done_cnt), 128'(target));
    end
    chk("overflow_clear", 128'(overflow), 128'd0);

    // Six words complete while the arbiter is busy: two are dropped, indices keep advancing.
    ram_busy = 1'b1;
    base     = obs_addr.size();
    target   = done_cnt + 1;
    frame_start = 1'b1;
    exp_sel     = 2'd0;
    tick();
    frame_start = 1'b0;
    send_pixels(48, 16'h0001);
    repeat (3) tick();
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_no_req_busy", 128'(obs_addr.size() - base), 128'd0);
    ram_busy = 1'b0;
    repeat (12) tick();
    chk("ovf_drain_count", 128'(obs_addr.size() - base), 128'd4);
    for (int i = 0; i < 4 && base + i < obs_addr.size(); i++)
      chk($sformatf("ovf_addr%0d", i), 128'(obs_addr[base+i]), 128'(8 * i));
    if (obs_addr.size() > base)
      chk("ovf_data0", obs_data[base], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    send_pixels(8, 16'h0100);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    wait_done(target, 200);
    repeat (4) tick();
    chk("ovf_total", 128'(obs_addr.size() - base), 128'd5);
    if (obs_addr.size() >= base + 5) begin
      chk("ovf_next_addr", 128'(obs_addr[base+4]), 128'd48);
      chk("ovf_next_data", obs_data[base+4], 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    end

    // Restart mid-frame: the partial word vanishes and the new base address applies.
    base   = obs_addr.size();
    target = done_cnt + 1;
    frame_start = 1'b1;
    exp_sel     = 2'd1;
    tick();
    frame_start = 1'b0;
    send_pixels(5, 16'h5555);
    frame_start = 1'b1;
    exp_sel     = 2'd2;
    tick();
    frame_start = 1'b0;
    exp_sel     = 2'd0;
    send_pixels(8, 16'h2000);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    wait_done(target, 200);
    repeat (4) tick();
    chk("abort_nreq", 128'(obs_addr.size() - base), 128'd1);
    if (obs_addr.size() > base) begin
      chk("abort_addr", 128'(obs_addr[base]), 128'h0100000);
      chk("abort_data", obs_data[base], 128'h2007_2006_2005_2004_2003_2002_2001_2000);
    end
    chk("abort_done_once", 128'(done_cnt), 128'(target));

    // Reset asserted between clock edges while a request is being presented.
    ram_busy = 1'b1;
    frame_start = 1'b1;
    exp_sel     = 2'd0;
    tick();
    frame_start = 1'b0;
    send_pixels(16, 16'h7000);
    repeat (3) tick();
    ram_busy = 1'b0;
    #1;
    chk("pre_reset_req", 128'(camera_wr_req), 128'd1);
    rst_n_133M = 1'b0;
    #1;
    chk("async_reset_ctrl", {125'd0, camera_wr_req, frame_done, overflow}, 128'd0);
    chk("async_reset_addr", 128'(camera_wr_address), 128'd0);
    chk("async_reset_data", camera_wr_data, 128'd0);
    repeat (2) tick();
    rst_n_133M = 1'b1;
    base   = obs_addr.size();
    target = done_cnt;
    tick();
    send_pixels(16, 16'h7100);
    repeat (10) tick();
    chk("post_reset_no_req", 128'(obs_addr.size() - base), 128'd0);
    chk("post_reset_no_done", 128'(done_cnt), 128'(target));
    pix_q.delete();
    for (int k = 0; k < 8; k++) pix_q.push_back(16'h3000 + 16'(k));
    target = done_cnt + 1;
    run_frame(2'd3, 1'b0, 1'b0);
    wait_done(target, 200);
    repeat (4) tick();
    chk("post_reset_nreq", 128'(obs_addr.size() - base), 128'd1);
    if (obs_addr.size() > base)
      chk("post_reset_addr", 128'(obs_addr[base]), 128'h0180000);

    // Random frames against the reference model, with a randomly busy arbiter.
    busy_mode = 1'b1;
    for (int f = 0; f < 6; f++) begin
      es = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, FW * 8 + 4);
      pix_q.delete();
      for (int k = 0; k < n; k++) pix_q.push_back(16'($urandom));
      build_expect(es);
      base   = obs_addr.size();
      target = done_cnt + 1;
      run_frame(es, 1'b1, 1'($urandom_range(0, 1)));
      wait_done(target, 2000);
      repeat (4) tick();
      compare_words(base, $sformatf("rand%0d", f));
      chk($sformatf("rand%0d_done_once", f), 128'(done_cnt), 128'(target));
    end
    busy_mode = 1'b0;
    ram_busy  = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
